// File: rtl/rowfetch_pkg.sv
// Shared types and constants for the row fetch scheduler.
package rowfetch_pkg;

  localparam int unsigned IMG_HEIGHT     = 64;
  localparam int unsigned ROW_WORDS      = 32;
  localparam int unsigned BURST_LEN      = 8;
  localparam int unsigned ADDR_W         = 24;
  localparam int unsigned DATA_W         = 32;

  localparam int unsigned ROW_W          = $clog2(IMG_HEIGHT);
  localparam int unsigned WIDX_W         = $clog2(ROW_WORDS);
  localparam int unsigned BSH            = $clog2(BURST_LEN);
  localparam int unsigned BURSTS_PER_ROW = ROW_WORDS / BURST_LEN;
  localparam int unsigned BIDX_W         = (BURSTS_PER_ROW > 1) ? $clog2(BURSTS_PER_ROW) : 1;
  localparam int unsigned FRAME_WORDS    = IMG_HEIGHT * ROW_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    DONE,
    WR_CMD
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    return ADDR_W'(r) * ADDR_W'(ROW_WORDS);
  endfunction

endpackage

// File: rtl/rowfetch_addr_gen.sv
// Registered SDRAM read address: bank base + row offset + burst offset.
module rowfetch_addr_gen
  import rowfetch_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic [ROW_W-1:0]  cur_row,
  input  logic [BIDX_W-1:0] burst_idx,
  input  logic [ADDR_W-1:0] bank_base,
  output logic [ADDR_W-1:0] rd_addr
);

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rd_addr <= '0;
    end else begin
      rd_addr <= bank_base + row_base(cur_row) + (ADDR_W'(burst_idx) << BSH);
    end
  end

endmodule

// File: rtl/row_fetch_scheduler.sv
// Row fetch scheduler: burst-reads display rows into the idle line-buffer half and
// shares the SDRAM command port with the loader. ROWFETCH_DBLFRAME_EN adds frame banking.
//
// state   | meaning
// IDLE    | wait for rowChange (priority) or loader wrReq
// RD_REQ  | present read burst command, wait for grant
// RD_DATA | write returning words into the idle buffer half
// DONE    | swap halves, count a late row event
// WR_CMD  | present one loader write command, wait for grant
module row_fetch_scheduler
  import rowfetch_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic [ROW_W-1:0]  row,
  input  logic              rowChange,
  output logic              rowChangeAck,
  input  logic              index,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memRdValid,
  input  logic [DATA_W-1:0] memRdData,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  output logic              wrGnt,
  output logic              lbWe,
  output logic [WIDX_W:0]   lbAddr,
  output logic [DATA_W-1:0] lbData,
  output logic              bufSel,
  output logic [15:0]       rowMiss
`ifdef ROWFETCH_DBLFRAME_EN
  ,
  output logic              rdBank
`endif
);

  fetch_state_t      state, state_nxt;
  logic [ROW_W-1:0]  cur_row;
  logic [WIDX_W:0]   word_cnt;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] bank_base;
  logic              burst_end;
  logic              row_end;
  logic              handshake;

  assign burst_end = (word_cnt[BSH-1:0] == BSH'(BURST_LEN - 1));
  assign row_end   = (word_cnt == (WIDX_W + 1)'(ROW_WORDS - 1));
  assign handshake = memReq && memGnt;

  rowfetch_addr_gen u_addr_gen (
    .clk       (clk),
    .nReset    (nReset),
    .cur_row   (cur_row),
    .burst_idx (word_cnt[BSH +: BIDX_W]),
    .bank_base (bank_base),
    .rd_addr   (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rowChange) begin
          state_nxt = RD_REQ;
        end else if (wrReq) begin
          state_nxt = WR_CMD;
        end
      end
      RD_REQ: begin
        if (handshake) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (memRdValid && burst_end) state_nxt = row_end ? DONE : RD_REQ;
      end
      DONE: state_nxt = IDLE;
      WR_CMD: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address is already registered in the generator and stays put while a
  // command is pending, so only the mux between read and loader address is needed.
  always_comb begin
    wrGnt   = (state == WR_CMD) && handshake;
    memAddr = memWe ? wr_addr_q : rd_addr;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rowChangeAck <= 1'b0;
      cur_row      <= '0;
      wr_addr_q    <= '0;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      lbWe         <= 1'b0;
      lbAddr       <= '0;
      lbData       <= '0;
      word_cnt     <= '0;
      bufSel       <= 1'b0;
      rowMiss      <= '0;
    end else begin
      rowChangeAck <= (state == IDLE) && rowChange;
      if ((state == IDLE) && rowChange) cur_row <= row;
      if ((state == IDLE) && !rowChange && wrReq) wr_addr_q <= wrAddr;

      memReq <= ((state == RD_REQ) || (state == WR_CMD)) && !handshake;
      memWe  <= (state == WR_CMD) && !handshake;

      lbWe <= (state == RD_DATA) && memRdValid;
      if ((state == RD_DATA) && memRdValid) begin
        lbAddr   <= {~bufSel, word_cnt[WIDX_W-1:0]};
        lbData   <= memRdData;
        word_cnt <= word_cnt + (WIDX_W + 1)'(1);
      end else if (state == DONE) begin
        word_cnt <= '0;
      end

      if (state == DONE) begin
        bufSel <= ~bufSel;
        if (rowChange && (rowMiss != 16'hFFFF)) rowMiss <= rowMiss + 16'd1;
      end
    end
  end

`ifdef ROWFETCH_DBLFRAME_EN
  logic frame_start;

  // Bank only flips while parked in IDLE, so a row never straddles two frames.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      frame_start <= 1'b0;
      rdBank      <= 1'b0;
    end else if ((state == IDLE) && frame_start) begin
      rdBank      <= ~rdBank;
      frame_start <= index;
    end else if (index) begin
      frame_start <= 1'b1;
    end
  end

  assign bank_base = rdBank ? ADDR_W'(FRAME_WORDS) : '0;
`else
  logic unused_index;
  assign unused_index = index;
  assign bank_base    = '0;
`endif

endmodule

// File: tb/tb_row_fetch_scheduler.sv
// Scoreboard bench for row_fetch_scheduler with a randomized SDRAM responder.
`timescale 1ns/1ps
module tb_row_fetch_scheduler;

  localparam int ROW_WORDS   = 32;
  localparam int BURST_LEN   = 8;
  localparam int FRAME_WORDS = 64 * 32;
  localparam int BOUND       = 600;

  logic        clk = 1'b0;
  logic        nReset;
  logic [5:0]  row;
  logic        rowChange, rowChangeAck, index;
  logic        memReq, memWe, memGnt, memRdValid;
  logic [23:0] memAddr, wrAddr;
  logic [31:0] memRdData, lbData;
  logic        wrReq, wrGnt, lbWe, bufSel;
  logic [5:0]  lbAddr;
  logic [15:0] rowMiss;
`ifdef ROWFETCH_DBLFRAME_EN
  logic        rdBank;
`endif

  always #5 clk = ~clk;

  row_fetch_scheduler dut (
    .clk(clk), .nReset(nReset), .row(row), .rowChange(rowChange),
    .rowChangeAck(rowChangeAck), .index(index), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memGnt(memGnt), .memRdValid(memRdValid), .memRdData(memRdData),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrGnt(wrGnt), .lbWe(lbWe), .lbAddr(lbAddr),
    .lbData(lbData), .bufSel(bufSel), .rowMiss(rowMiss)
`ifdef ROWFETCH_DBLFRAME_EN
    , .rdBank(rdBank)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {8'hA5, a} ^ (32'(a) * 32'h9E3779B1);
  endfunction

  // SDRAM responder: random grant wait, random read latency, gappy data beats.
  logic        m_gnt, m_valid, m_we, stray_valid;
  logic [31:0] m_data, stray_data;
  logic [23:0] m_addr;
  int          ms, m_wait, m_lat, m_beat;

  assign memGnt     = m_gnt;
  assign memRdValid = m_valid | stray_valid;
  assign memRdData  = m_valid ? m_data : stray_data;

  always @(posedge clk) begin
    if (!nReset) begin
      ms <= 0; m_gnt <= 1'b0; m_valid <= 1'b0; m_data <= '0;
    end else begin
      m_gnt   <= 1'b0;
      m_valid <= 1'b0;
      case (ms)
        0: if (memReq) begin m_wait <= $urandom_range(0, 3); ms <= 1; end
        1: if (m_wait == 0) begin
             m_gnt <= 1'b1; m_we <= memWe; m_addr <= memAddr; ms <= 2;
           end else m_wait <= m_wait - 1;
        2: if (m_we) ms <= 0;
           else begin m_lat <= $urandom_range(0, 3); m_beat <= 0; ms <= 3; end
        3: if (m_lat == 0) ms <= 4; else m_lat <= m_lat - 1;
        4: if ($urandom_range(0, 3) != 0) begin
             m_valid <= 1'b1;
             m_data  <= mem_word(m_addr + 24'(m_beat));
             m_beat  <= m_beat + 1;
             if (m_beat == BURST_LEN - 1) ms <= 0;
           end
        default: ms <= 0;
      endcase
    end
  end

  typedef struct packed { logic we; logic [23:0] addr; } cmd_t;
  typedef struct packed { logic [5:0] addr; logic [31:0] data; } lbw_t;

  cmd_t cmd_q[$];
  lbw_t lb_q[$];
  logic bsel_q[$];
  cmd_t e_cmd;
  lbw_t e_lb;

  int checks = 0, errors = 0;
  int lb_seen = 0, ack_seen = 0;
  logic p_req, p_lbwe, p_bsel, p_ack;
  logic [23:0] p_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a command, write or swap.
  always @(negedge clk) begin
    if (nReset === 1'b1) begin
      if (lbWe) begin
        lb_seen++;
        if (lb_q.size() == 0) chk("lb_unexpected", lbWe, 0);
        else begin
          e_lb = lb_q.pop_front();
          chk("lb_addr", lbAddr, e_lb.addr);
          chk("lb_data", lbData, e_lb.data);
        end
      end
      if (memReq && memGnt) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", memReq, 0);
        else begin
          e_cmd = cmd_q.pop_front();
          chk("cmd_we", memWe, e_cmd.we);
          chk("cmd_addr", memAddr, e_cmd.addr);
          chk("wr_gnt", wrGnt, e_cmd.we);
        end
      end else if (wrGnt) chk("wr_gnt_stray", wrGnt, 0);
      if (memReq && p_req) chk("addr_stable", memAddr, p_addr);
      if (bufSel !== p_bsel) begin
        if (bsel_q.size() == 0) chk("bufsel_unexpected", bufSel, p_bsel);
        else chk("bufsel_val", bufSel, bsel_q.pop_front());
        chk("bufsel_after_lbwe", p_lbwe, 1);
      end
      if (rowChangeAck) begin
        ack_seen++;
        chk("ack_width", p_ack, 0);
      end
    end
    p_req = memReq; p_addr = memAddr; p_lbwe = lbWe; p_bsel = bufSel; p_ack = rowChangeAck;
  end

  logic exp_bsel;
  int   exp_miss, exp_bank, exp_acks;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_row(input int r);
    logic [23:0] base;
    base = 24'(exp_bank * FRAME_WORDS + r * ROW_WORDS);
    for (int k = 0; k < ROW_WORDS / BURST_LEN; k++)
      cmd_q.push_back('{we: 1'b0, addr: base + 24'(k * BURST_LEN)});
    for (int i = 0; i < ROW_WORDS; i++)
      lb_q.push_back('{addr: {~exp_bsel, 5'(i)}, data: mem_word(base + 24'(i))});
    exp_bsel = ~exp_bsel;
    bsel_q.push_back(exp_bsel);
    exp_acks++;
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (rowChangeAck !== 1'b1 && n < BOUND) begin tick(); n++; end
    chk({nm, "_ack"}, rowChangeAck, 1);
  endtask

  task automatic wait_wrgnt(input string nm);
    int n = 0;
    while (wrGnt !== 1'b1 && n < BOUND) begin tick(); n++; end
    chk({nm, "_wrgnt"}, wrGnt, 1);
  endtask

  task automatic wait_lb(input string nm, input int target);
    int n = 0;
    while (lb_seen < target && n < BOUND) begin tick(); n++; end
    chk({nm, "_lb_count"}, (lb_seen >= target), 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((cmd_q.size() + lb_q.size() + bsel_q.size()) != 0 && n < BOUND) begin tick(); n++; end
    repeat (3) tick();
    chk({nm, "_drain"}, cmd_q.size() + lb_q.size() + bsel_q.size(), 0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ack"},    rowChangeAck, 0);
    chk({nm, "_req"},    memReq, 0);
    chk({nm, "_we"},     memWe, 0);
    chk({nm, "_addr"},   memAddr, 0);
    chk({nm, "_wrgnt"},  wrGnt, 0);
    chk({nm, "_lbwe"},   lbWe, 0);
    chk({nm, "_lbaddr"}, lbAddr, 0);
    chk({nm, "_lbdata"}, lbData, 0);
    chk({nm, "_bufsel"}, bufSel, 0);
    chk({nm, "_miss"},   rowMiss, 0);
`ifdef ROWFETCH_DBLFRAME_EN
    chk({nm, "_bank"},   rdBank, 0);
`endif
  endtask

  task automatic fetch(input string nm, input int r, input bit with_wr);
    push_row(r);
    row = 6'(r); rowChange = 1'b1;
    if (with_wr) begin
      wrAddr = 24'($urandom); wrReq = 1'b1;
      cmd_q.push_back('{we: 1'b1, addr: wrAddr});
    end
    wait_ack(nm);
    rowChange = 1'b0;
    if (with_wr) begin
      wait_wrgnt(nm);
      wrReq = 1'b0;
    end
    drain(nm);
  endtask

  task automatic loader_write(input string nm);
    wrAddr = 24'($urandom); wrReq = 1'b1;
    cmd_q.push_back('{we: 1'b1, addr: wrAddr});
    wait_wrgnt(nm);
    wrReq = 1'b0;
    drain(nm);
  endtask

  initial begin
    int base_lb;
    nReset = 1'b0; row = '0; rowChange = 1'b0; index = 1'b0; wrReq = 1'b0;
    wrAddr = '0; stray_valid = 1'b0; stray_data = '0;
    exp_bsel = 1'b0; exp_miss = 0; exp_bank = 0; exp_acks = 0;
    repeat (3) tick();
    check_reset("rst0");
    nReset = 1'b1;
    tick();

    // row 5: reads at 160..184 into half 1
    push_row(5);
    row = 6'd5; rowChange = 1'b1;
    wait_ack("single");
    rowChange = 1'b0;
    tick();
    chk("single_ack_one_cycle", rowChangeAck, 0);
    drain("single");
    chk("single_bufsel", bufSel, 1);

    stray_valid = 1'b1;
    repeat (4) begin stray_data = $urandom; tick(); end
    stray_valid = 1'b0;
    tick();
    chk("stray_req", memReq, 0);
    chk("stray_lbwe", lbWe, 0);

    fetch("contention", 9, 1'b1);

    // row 8 event arrives while row 7 is still filling
    push_row(7);
    row = 6'd7; rowChange = 1'b1;
    wait_ack("late7");
    rowChange = 1'b0;
    wait_lb("late7", lb_seen + 5);
    push_row(8);
    exp_miss++;
    row = 6'd8; rowChange = 1'b1;
    wait_ack("late8");
    chk("late_ack_after_swap", bsel_q.size(), 1);
    rowChange = 1'b0;
    drain("late8");
    chk("late_miss", rowMiss, 16'(exp_miss));

    for (int it = 0; it < 8; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
`ifndef ROWFETCH_DBLFRAME_EN
      index = 1'b1; tick(); index = 1'b0;
`endif
      if (kind == 0) loader_write("rand_wr");
      else fetch("rand_row", $urandom_range(0, 63), kind == 3);
    end

`ifdef ROWFETCH_DBLFRAME_EN
    index = 1'b1; tick(); index = 1'b0;
    repeat (2) tick();
    chk("bank_swap", rdBank, 1);
    exp_bank = 1;
    fetch("bank_row0", 0, 1'b0);
`endif

    push_row(20);
    row = 6'd20; rowChange = 1'b1;
    wait_ack("rstmid");
    rowChange = 1'b0;
    base_lb = lb_seen;
    wait_lb("rstmid", base_lb + 10);
    row = 6'd21; rowChange = 1'b1;
    nReset = 1'b0;
    tick();
    cmd_q.delete(); lb_q.delete(); bsel_q.delete();
    exp_bsel = 1'b0; exp_miss = 0; exp_bank = 0;
    tick();
    check_reset("rst_mid");
    push_row(21);
    nReset = 1'b1;
    wait_ack("rst_reack");
    rowChange = 1'b0;
    drain("rst_reack");
    chk("rst_reack_bufsel", bufSel, 1);

    chk("ack_total", ack_seen, exp_acks);
    chk("final_miss", rowMiss, 16'(exp_miss));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
